// File: rtl/freq_line_writer.sv
// freq_line_writer
//   Feeds the waterfall frequency BRAM. Each FFT frame becomes one display
//   line: complex bins stream in, |re|+|im| is formed, shifted and saturated
//   to a pixel byte, and written to BRAM at {line, bin}. Lines fill a
//   circular buffer; line_ptr tells the display reader which line is newest.
//
// Ports
//   clk          system clock (also the BRAM write clock)
//   reset        asynchronous, active-high
//   frame_start  pulse: next accepted bin is bin 0 of a new line
//   bin_valid    bin_re/bin_im valid
//   bin_ready    bin accepted when bin_valid && bin_ready (CAPTURE only)
//   bin_re       signed real part
//   bin_im       signed imaginary part
//   w_en         BRAM write enable
//   w_addr       BRAM write address {line, bin}
//   d_in         BRAM write data (pixel)
//   line_ptr     index of the most recently completed line
//   line_done    one-cycle pulse when a line commits
module freq_line_writer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int BINS_W = 5,
  parameter int MAG_W  = 16,
  parameter int SHIFT  = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       bin_valid,
  output logic                       bin_ready,
  input  logic signed [MAG_W-1:0]    bin_re,
  input  logic signed [MAG_W-1:0]    bin_im,
  output logic                       w_en,
  output logic [ADDR_W-1:0]          w_addr,
  output logic [DATA_W-1:0]          d_in,
  output logic [ADDR_W-BINS_W-1:0]   line_ptr,
  output logic                       line_done
);

  localparam int LINE_W = ADDR_W - BINS_W;
  localparam logic [MAG_W:0] SAT_MAX = {{(MAG_W+1-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BINS_W-1:0]   bin_cnt;
  logic [BINS_W-1:0]   bin_cnt_next;
  logic [BINS_W-1:0]   bin_idx;
  logic [LINE_W-1:0]   wr_line;
  logic                accept;
  logic                s1_valid;
  logic [MAG_W:0]      s1_mag;
  logic [ADDR_W-1:0]   s1_addr;

  // Absolute value widened by one bit so that |-2^(MAG_W-1)| is exact.
  function automatic logic [MAG_W:0] abs_mag(input logic [MAG_W-1:0] v);
    logic [MAG_W:0] ext;
    ext = {v[MAG_W-1], v};
    if (v[MAG_W-1]) begin
      abs_mag = ~ext + {{MAG_W{1'b0}}, 1'b1};
    end else begin
      abs_mag = ext;
    end
  endfunction

  // Scale the magnitude down and clamp it to the largest pixel value.
  function automatic logic [DATA_W-1:0] sat_pixel(input logic [MAG_W:0] m);
    logic [MAG_W:0] sh;
    sh = m >> SHIFT;
    if (sh > SAT_MAX) begin
      sat_pixel = {DATA_W{1'b1}};
    end else begin
      sat_pixel = sh[DATA_W-1:0];
    end
  endfunction

  assign accept  = bin_valid && bin_ready;
  // A frame_start coinciding with an accept restarts the line at that bin.
  assign bin_idx = frame_start ? {BINS_W{1'b0}} : bin_cnt;

  // Next-state and bin-count logic.
  always_comb begin
    state_next   = state;
    bin_cnt_next = bin_cnt;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_next   = CAPTURE;
          bin_cnt_next = {BINS_W{1'b0}};
        end else begin
          state_next   = IDLE;
        end
      end
      CAPTURE: begin
        if (accept) begin
          if (bin_idx == {BINS_W{1'b1}}) begin
            state_next   = DRAIN;
            bin_cnt_next = {BINS_W{1'b0}};
          end else begin
            bin_cnt_next = bin_idx + {{(BINS_W-1){1'b0}}, 1'b1};
          end
        end else if (frame_start) begin
          bin_cnt_next = {BINS_W{1'b0}};
        end else begin
          bin_cnt_next = bin_cnt;
        end
      end
      DRAIN: begin
        if (!s1_valid) begin
          state_next = COMMIT;
        end else begin
          state_next = DRAIN;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        bin_cnt_next = {BINS_W{1'b0}};
      end
    endcase
  end

  // FSM state, handshake and line bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bin_cnt   <= {BINS_W{1'b0}};
      bin_ready <= 1'b0;
      line_done <= 1'b0;
      line_ptr  <= {LINE_W{1'b1}};
      wr_line   <= {LINE_W{1'b0}};
    end else begin
      state     <= state_next;
      bin_cnt   <= bin_cnt_next;
      bin_ready <= (state_next == CAPTURE);
      line_done <= (state_next == COMMIT);
      // COMMIT is only entered from DRAIN, so this fires once per line.
      if (state_next == COMMIT) begin
        line_ptr <= wr_line;
        wr_line  <= wr_line + {{(LINE_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Stage 1: magnitude and destination address of the accepted bin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mag   <= {(MAG_W+1){1'b0}};
      s1_addr  <= {ADDR_W{1'b0}};
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_mag  <= abs_mag(bin_re) + abs_mag(bin_im);
        s1_addr <= {wr_line, bin_idx};
      end
    end
  end

  // Stage 2: BRAM write port; address/data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_en   <= 1'b0;
      w_addr <= {ADDR_W{1'b0}};
      d_in   <= {DATA_W{1'b0}};
    end else begin
      w_en <= s1_valid;
      if (s1_valid) begin
        w_addr <= s1_addr;
        d_in   <= sat_pixel(s1_mag);
      end
    end
  end

endmodule

// File: tb/tb_freq_line_writer.sv
// Randomized bench for freq_line_writer with a line/bin reference model.
// A second instance built with SHIFT=0 exercises pixel saturation.
module tb_freq_line_writer;

  logic              clk;
  logic              reset;
  logic              frame_start;
  logic              bin_valid;
  logic signed [15:0] bin_re;
  logic signed [15:0] bin_im;

  logic              bin_ready, bin_ready0;
  logic              w_en, w_en0;
  logic [8:0]        w_addr, w_addr0;
  logic [7:0]        d_in, d_in0;
  logic [3:0]        line_ptr, line_ptr0;
  logic              line_done, line_done0;

  freq_line_writer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .bin_valid(bin_valid),
    .bin_ready(bin_ready), .bin_re(bin_re), .bin_im(bin_im), .w_en(w_en),
    .w_addr(w_addr), .d_in(d_in), .line_ptr(line_ptr), .line_done(line_done)
  );

  freq_line_writer #(.SHIFT(0)) dut_sat (
    .clk(clk), .reset(reset), .frame_start(frame_start), .bin_valid(bin_valid),
    .bin_ready(bin_ready0), .bin_re(bin_re), .bin_im(bin_im), .w_en(w_en0),
    .w_addr(w_addr0), .d_in(d_in0), .line_ptr(line_ptr0), .line_done(line_done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int addr;
    int d9;
    int d0;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  lines = 0;
  // reference model state
  bit  m_cap;
  bit  pending;
  int  pend_age;
  int  m_cnt;
  int  m_line;
  int  m_ptr;
  // stimulus knobs
  int  p_valid;
  int  p_abandon;
  int  p_start;
  int  val_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick_val();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: pick_val = -32768;
      1: pick_val = 32767;
      2: pick_val = 0;
      3: pick_val = -1;
      4: pick_val = 512;
      5: pick_val = -300;
      6: pick_val = 255;
      default: pick_val = $urandom_range(0, 65535) - 32768;
    endcase
  endfunction

  function automatic int min255(input int v);
    min255 = (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cap = 1'b0; pending = 1'b0; pend_age = 0;
    m_cnt = 0; m_line = 0; m_ptr = 15;
  endtask

  // One clock: check outputs at the falling edge, then drive the next inputs.
  task automatic step();
    bit exp_en, commit_now, fs, vld, acc;
    int re, im, mag;
    wr_t e;
    @(negedge clk);
    cyc++;
    exp_en = (q.size() > 0) && (q[0].due == cyc);
    check("w_en", w_en, exp_en);
    check("w_en_sat", w_en0, exp_en);
    if (exp_en) begin
      e = q.pop_front();
      check("w_addr", w_addr, e.addr);
      check("d_in", d_in, e.d9);
      check("w_addr_sat", w_addr0, e.addr);
      check("d_in_sat", d_in0, e.d0);
    end
    check("bin_ready", bin_ready, m_cap);
    check("bin_ready_sat", bin_ready0, m_cap);
    commit_now = 1'b0;
    if (line_done) begin
      check("line_done_expected", pending, 1'b1);
      commit_now = 1'b1;
      m_ptr = m_line;
      m_line = (m_line + 1) % 16;
      lines++;
    end else if (pending) begin
      pend_age++;
      if (pend_age > 8) begin
        check("commit_timeout", 0, 1);
        pending = 1'b0;
      end
    end
    check("line_ptr", line_ptr, m_ptr);
    check("line_ptr_sat", line_ptr0, m_ptr);

    // stimulus
    if (m_cap)                      fs = ($urandom_range(0, 99) < p_abandon);
    else if (pending || commit_now) fs = ($urandom_range(0, 99) < 20);
    else                            fs = ($urandom_range(0, 99) < p_start);
    vld = ($urandom_range(0, 99) < p_valid);
    if (val_mode == 0) begin
      re = 512; im = 0;
    end else begin
      re = pick_val(); im = pick_val();
    end
    frame_start = fs;
    bin_valid   = vld;
    bin_re      = 16'(re);
    bin_im      = 16'(im);

    if (commit_now) pending = 1'b0;
    acc = vld && m_cap;
    if (fs && m_cap) m_cnt = 0;
    if (acc) begin
      mag = (re < 0 ? -re : re) + (im < 0 ? -im : im);
      e.due = cyc + 2;
      e.addr = m_line * 32 + m_cnt;
      e.d9 = min255(mag >> 9);
      e.d0 = min255(mag);
      q.push_back(e);
      m_cnt++;
      if (m_cnt == 32) begin
        m_cap = 1'b0; pending = 1'b1; pend_age = 0; m_cnt = 0;
      end
    end else if (fs && !m_cap && !pending && !commit_now) begin
      m_cap = 1'b1;
      m_cnt = 0;
    end
  endtask

  task automatic run_lines(input int target);
    int start, n;
    start = lines;
    n = 0;
    while ((lines - start) < target && n < 4000) begin
      step();
      n++;
    end
    if ((lines - start) < target) check("run_lines_timeout", lines - start, target);
  endtask

  initial begin
    frame_start = 1'b0; bin_valid = 1'b0; bin_re = 16'sd0; bin_im = 16'sd0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_w_en", w_en, 1'b0);
    check("rst_w_addr", w_addr, 9'd0);
    check("rst_d_in", d_in, 8'd0);
    check("rst_ready", bin_ready, 1'b0);
    check("rst_line_done", line_done, 1'b0);
    check("rst_line_ptr", line_ptr, 4'hf);
    reset = 1'b0;

    // Directed: constant 512+0j bins, full-rate, 17 lines (wraps the buffer).
    val_mode = 0; p_valid = 100; p_abandon = 0; p_start = 100;
    run_lines(17);
    check("ptr_after_17", line_ptr, 4'd0);

    // Random values, gappy valid, occasional abandon.
    val_mode = 1; p_valid = 60; p_abandon = 3; p_start = 30;
    run_lines(6);

    // Reset in the middle of a line.
    p_valid = 100; p_abandon = 0; p_start = 100;
    begin
      int n;
      n = 0;
      while (!(m_cap && m_cnt >= 20) && n < 500) begin
        step();
        n++;
      end
      if (n >= 500) check("reach_mid_line", 0, 1);
    end
    @(negedge clk);
    cyc++;
    reset = 1'b1;
    frame_start = 1'b0; bin_valid = 1'b0;
    model_reset();
    #1;
    check("midrst_w_en", w_en, 1'b0);
    check("midrst_line_ptr", line_ptr, 4'hf);
    check("midrst_ready", bin_ready, 1'b0);
    check("midrst_line_done", line_done, 1'b0);
    @(negedge clk);
    cyc++;
    check("midrst_w_en_hold", w_en, 1'b0);
    reset = 1'b0;

    // After reset the next line must land at line 0.
    p_valid = 80; p_start = 50;
    run_lines(2);
    check("ptr_after_reset", line_ptr, 4'd1);

    // Quiesce and confirm nothing was left unwritten.
    p_valid = 0; p_start = 0; p_abandon = 0;
    repeat (12) step();
    check("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
